// File: rtl/counter_arb_pkg.sv
// rtl/counter_arb_pkg.sv - shared types and helpers for the counter arbiter
// Contents:
//   arb_state_t  arbiter state encoding (IDLE, RUN, DONE, CLEAR)
//   clog2()      index width for a requester count, never less than 1
package counter_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    CLEAR = 2'd3
  } arb_state_t;

  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/counter.sv
// rtl/counter.sv - saturating up-counter with finished flag
// Ports:
//   clock_i     system clock, rising edge
//   reset_i     asynchronous active-high reset/clear
//   enable_i    count one step per enabled edge
//   count_o     registered counter value, saturates at MAX_COUNTER_VALUE
//   finished_o  high while count_o equals MAX_COUNTER_VALUE
module counter #(
  parameter int MAX_COUNTER_VALUE = 160
) (
  input  logic                                   clock_i,
  input  logic                                   reset_i,
  input  logic                                   enable_i,
  output logic [$clog2(MAX_COUNTER_VALUE+1)-1:0] count_o,
  output logic                                   finished_o
);
  localparam int CW = $clog2(MAX_COUNTER_VALUE + 1);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      count_o <= '0;
    end else if (enable_i && (count_o != CW'(MAX_COUNTER_VALUE))) begin
      count_o <= count_o + CW'(1);
    end
  end

  assign finished_o = (count_o == CW'(MAX_COUNTER_VALUE));

endmodule

// File: rtl/counter_arb_pick.sv
// rtl/counter_arb_pick.sv - combinational winner selection for the counter arbiter
// Build macro: COUNTER_ARB_FIXED_PRIO_EN selects lowest-index-wins; otherwise round-robin from ptr.
// Ports:
//   req     request vector
//   ptr     round-robin start index (ignored in the fixed-priority build)
//   winner  index of the selected requester
//   valid   at least one request is set
module counter_arb_pick
  import counter_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      winner,
  output logic               valid
);
  logic [IW:0]   sum;
  logic [IW-1:0] cand;

`ifdef COUNTER_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    sum    = '0;
    cand   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
`ifdef COUNTER_ARB_FIXED_PRIO_EN
      sum  = (IW+1)'(k);
`else
      // ptr + k wrapped once into 0..NUM_REQ-1; ptr never exceeds NUM_REQ-1
      sum  = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
`endif
      cand = sum[IW-1:0];
      if (req[cand]) begin
        winner = cand;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// rtl/counter_arbiter.sv - shares one counter between NUM_REQ timing requesters
// Build macro: COUNTER_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
// Ports:
//   clock_i        system clock, rising edge
//   reset_i        asynchronous active-high reset
//   req_i          per-requester request level, held until done_o or abort
//   grant_o        one-hot grant to the requester owning the counter
//   done_o         one-cycle completion pulse to the granted requester
//   busy_o         high whenever the arbiter is not idle
//   counter_val_o  live value of the shared counter
module counter_arbiter
  import counter_arb_pkg::*;
#(
  parameter int MAX_COUNTER_VALUE = 160,
  parameter int NUM_REQ           = 4
) (
  input  logic                                   clock_i,
  input  logic                                   reset_i,
  input  logic [NUM_REQ-1:0]                     req_i,
  output logic [NUM_REQ-1:0]                     grant_o,
  output logic [NUM_REQ-1:0]                     done_o,
  output logic                                   busy_o,
  output logic [$clog2(MAX_COUNTER_VALUE+1)-1:0] counter_val_o
);
  localparam int IW = clog2(NUM_REQ);

  arb_state_t    state;
  logic [IW-1:0] gidx;
  logic          clr_q;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;
  logic [IW-1:0] pick_ptr;
  logic          cnt_rst;
  logic          cnt_en;
  logic          cnt_finished;

`ifndef COUNTER_ARB_FIXED_PRIO_EN
  logic [IW-1:0] rr_ptr;
  assign pick_ptr = rr_ptr;
`else
  assign pick_ptr = '0;
`endif

  counter_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req    (req_i),
    .ptr    (pick_ptr),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  // clr_q is a register output, so the derived counter reset is glitch-free.
  assign cnt_rst = reset_i | clr_q;
  assign cnt_en  = (state == RUN) && req_i[gidx];

  counter #(
    .MAX_COUNTER_VALUE (MAX_COUNTER_VALUE)
  ) u_counter (
    .clock_i    (clock_i),
    .reset_i    (cnt_rst),
    .enable_i   (cnt_en),
    .count_o    (counter_val_o),
    .finished_o (cnt_finished)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state   <= IDLE;
      gidx    <= '0;
      grant_o <= '0;
      done_o  <= '0;
      busy_o  <= 1'b0;
      clr_q   <= 1'b0;
`ifndef COUNTER_ARB_FIXED_PRIO_EN
      rr_ptr  <= '0;
`endif
    end else begin
      done_o <= '0;
      clr_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state   <= RUN;
            gidx    <= pick_idx;
            grant_o <= NUM_REQ'(1) << pick_idx;
            busy_o  <= 1'b1;
`ifndef COUNTER_ARB_FIXED_PRIO_EN
            // The winner becomes lowest priority for the next round.
            rr_ptr  <= (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);
`endif
          end
        end
        RUN: begin
          // Finishing takes precedence over a request drop in the same cycle.
          if (cnt_finished) begin
            state  <= DONE;
            done_o <= grant_o;
          end else if (!req_i[gidx]) begin
            state   <= CLEAR;
            grant_o <= '0;
            clr_q   <= 1'b1;
          end
        end
        DONE: begin
          state   <= CLEAR;
          grant_o <= '0;
          clr_q   <= 1'b1;
        end
        CLEAR: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          grant_o <= '0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// tb/tb_counter_arbiter.sv - self-checking bench for counter_arbiter (MAX=5, NUM_REQ=3)
module tb_counter_arbiter;
  localparam int MAX = 5;
  localparam int NR  = 3;
  localparam int CW  = $clog2(MAX + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req;
  logic [NR-1:0] grant;
  logic [NR-1:0] done;
  logic          busy;
  logic [CW-1:0] cnt;

  int checks = 0;
  int errors = 0;

  counter_arbiter #(
    .MAX_COUNTER_VALUE (MAX),
    .NUM_REQ           (NR)
  ) dut (
    .clock_i       (clk),
    .reset_i       (rst),
    .req_i         (req),
    .grant_o       (grant),
    .done_o        (done),
    .busy_o        (busy),
    .counter_val_o (cnt)
  );

  always #5 clk = ~clk;

  function automatic bit has(input logic [NR-1:0] v, input int i);
    logic [NR-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant got %b exp 000", grant); end
    checks++; if (done !== '0) begin errors++; $display("FAIL reset_done got %b exp 000", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [NR-1:0] eg, ed;
    int ec;
    logic eb;
    req = 3'b010;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      eg = (c <= MAX + 1) ? 3'b010 : 3'b000;
      ed = (c == MAX + 1) ? 3'b010 : 3'b000;
      ec = (c <= MAX + 1) ? ((c < MAX) ? c : MAX) : 0;
      eb = (c <= MAX + 2);
      checks++; if (grant !== eg) begin errors++; $display("FAIL single_grant c=%0d got %b exp %b", c, grant, eg); end
      checks++; if (done !== ed) begin errors++; $display("FAIL single_done c=%0d got %b exp %b", c, done, ed); end
      checks++; if (cnt !== CW'(ec)) begin errors++; $display("FAIL single_cnt c=%0d got %0d exp %0d", c, cnt, ec); end
      checks++; if (busy !== eb) begin errors++; $display("FAIL single_busy c=%0d got %b exp %b", c, busy, eb); end
      if (c == MAX + 1) req = '0;
    end
  endtask

  task automatic test_rr_all();
    logic [NR-1:0] eg, ed, who;
    int k, j;
    apply_reset();
    req = 3'b111;
    for (int c = 0; c < 4 * (MAX + 4); c++) begin
      @(negedge clk);
      k = c % (MAX + 4);
      j = c / (MAX + 4);
`ifdef COUNTER_ARB_FIXED_PRIO_EN
      who = 3'b001;
`else
      who = NR'(1) << (j % NR);
`endif
      eg = (k <= MAX + 1) ? who : '0;
      ed = (k == MAX + 1) ? who : '0;
      checks++; if (grant !== eg) begin errors++; $display("FAIL rr_grant c=%0d got %b exp %b", c, grant, eg); end
      checks++; if (done !== ed) begin errors++; $display("FAIL rr_done c=%0d got %b exp %b", c, done, ed); end
    end
    req = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_abort();
    logic [NR-1:0] eg [7];
    int            ec [7];
    logic          eb [7];
    eg = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b010};
    ec = '{0, 1, 2, 3, 0, 0, 0};
    eb = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    apply_reset();
    req = 3'b111;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checks++; if (grant !== eg[c]) begin errors++; $display("FAIL abort_grant c=%0d got %b exp %b", c, grant, eg[c]); end
      checks++; if (done !== '0) begin errors++; $display("FAIL abort_done c=%0d got %b exp 000", c, done); end
      checks++; if (cnt !== CW'(ec[c])) begin errors++; $display("FAIL abort_cnt c=%0d got %0d exp %0d", c, cnt, ec[c]); end
      checks++; if (busy !== eb[c]) begin errors++; $display("FAIL abort_busy c=%0d got %b exp %b", c, busy, eb[c]); end
      if (c == 3) req = 3'b110;
    end
    req = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_finish_drop();
    logic [NR-1:0] eg, ed;
    int ec;
    apply_reset();
    req = 3'b001;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      eg = (c <= MAX + 1) ? 3'b001 : 3'b000;
      ed = (c == MAX + 1) ? 3'b001 : 3'b000;
      ec = (c <= MAX + 1) ? ((c < MAX) ? c : MAX) : 0;
      checks++; if (grant !== eg) begin errors++; $display("FAIL fdrop_grant c=%0d got %b exp %b", c, grant, eg); end
      checks++; if (done !== ed) begin errors++; $display("FAIL fdrop_done c=%0d got %b exp %b", c, done, ed); end
      checks++; if (cnt !== CW'(ec)) begin errors++; $display("FAIL fdrop_cnt c=%0d got %0d exp %0d", c, cnt, ec); end
      if (c == MAX) req = '0;
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    req = 3'b010;
    repeat (3) @(negedge clk);
    checks++; if (cnt !== CW'(2)) begin errors++; $display("FAIL areset_pre_cnt got %0d exp 2", cnt); end
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL areset_pre_grant got %b exp 010", grant); end
    #2 rst = 1'b1;
    #1;
    checks++; if (grant !== '0) begin errors++; $display("FAIL areset_grant got %b exp 000", grant); end
    checks++; if (done !== '0) begin errors++; $display("FAIL areset_done got %b exp 000", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b exp 0", busy); end
    checks++; if (cnt !== '0) begin errors++; $display("FAIL areset_cnt got %0d exp 0", cnt); end
    @(negedge clk);
    rst = 1'b0;
    req = 3'b111;
    @(negedge clk);
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL areset_restart got %b exp 001", grant); end
    req = '0;
    repeat (4) @(negedge clk);
  endtask

  // Each round: a random requester subset raised together, each either held
  // to completion or dropped when the counter shows a random value.
  task automatic test_random();
    int ptr;
    apply_reset();
    ptr = 0;
    for (int r = 0; r < 14; r++) begin
      logic [NR-1:0] rset, pend, drv, eg, ed;
      int ab [NR];
      int st [NR];
      int lst [NR];
      int t, w, total, ec;
      logic eb;
      rset = NR'($urandom_range(1, (1 << NR) - 1));
      for (int i = 0; i < NR; i++) begin
        ab[i]  = ($urandom_range(0, 1) == 1) ? MAX + 1 : int'($urandom_range(0, MAX));
        lst[i] = (ab[i] < MAX) ? ab[i] : MAX + 1;
        st[i]  = 0;
      end
      pend = rset;
      t    = 0;
      while (pend != '0) begin
        w = -1;
        for (int k = 0; k < NR; k++) begin
`ifdef COUNTER_ARB_FIXED_PRIO_EN
          if (w < 0 && has(pend, k)) w = k;
`else
          if (w < 0 && has(pend, (ptr + k) % NR)) w = (ptr + k) % NR;
`endif
        end
        st[w] = t;
        pend  = pend & ~(NR'(1) << w);
        ptr   = (w + 1) % NR;
        t     = t + lst[w] + 3;
      end
      total = t;
      drv   = rset;
      req   = drv;
      for (int c = 0; c < total; c++) begin
        @(negedge clk);
        eg = '0;
        ed = '0;
        ec = 0;
        eb = 1'b0;
        for (int i = 0; i < NR; i++) begin
          int k;
          k = c - st[i];
          if (has(rset, i) && k >= 0) begin
            if (k <= lst[i]) begin
              eg = eg | (NR'(1) << i);
              ec = (k < MAX) ? k : MAX;
            end
            if (k == MAX + 1 && ab[i] >= MAX) ed = ed | (NR'(1) << i);
            if (k <= lst[i] + 1) eb = 1'b1;
          end
        end
        checks++; if (grant !== eg) begin errors++; $display("FAIL rnd_grant r=%0d c=%0d got %b exp %b", r, c, grant, eg); end
        checks++; if (done !== ed) begin errors++; $display("FAIL rnd_done r=%0d c=%0d got %b exp %b", r, c, done, ed); end
        checks++; if (cnt !== CW'(ec)) begin errors++; $display("FAIL rnd_cnt r=%0d c=%0d got %0d exp %0d", r, c, cnt, ec); end
        checks++; if (busy !== eb) begin errors++; $display("FAIL rnd_busy r=%0d c=%0d got %b exp %b", r, c, busy, eb); end
        checks++; if (!$onehot0(grant)) begin errors++; $display("FAIL rnd_grant_onehot r=%0d c=%0d got %b exp at most one bit", r, c, grant); end
        checks++; if (!$onehot0(done)) begin errors++; $display("FAIL rnd_done_onehot r=%0d c=%0d got %b exp at most one bit", r, c, done); end
        checks++; if ((done & ~grant) !== '0) begin errors++; $display("FAIL rnd_done_ungranted r=%0d c=%0d got done %b grant %b exp done within grant", r, c, done, grant); end
        for (int i = 0; i < NR; i++) begin
          if (has(rset, i) && c == st[i] + ab[i]) drv = drv & ~(NR'(1) << i);
        end
        req = drv;
      end
    end
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    test_reset();
    test_single();
    test_rr_all();
    test_abort();
    test_finish_drop();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
